// File: rtl/climate_classify_arbiter_if.sv
// Station and classifier signals around climate_classify_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface climate_classify_arbiter_if #(
    parameter int unsigned N_STATIONS = 4
);
    logic [N_STATIONS-1:0]    req_valid;
    logic [32*N_STATIONS-1:0] req_temperature;
    logic [32*N_STATIONS-1:0] req_pressure;
    logic [N_STATIONS-1:0]    req_ready;
    logic [N_STATIONS-1:0]    rsp_valid;
    logic [N_STATIONS-1:0]    rsp_ready;
    logic [1:0]               rsp_class;
    logic                     rsp_timeout;
    logic                     cls_start;
    logic [31:0]              cls_temperature;
    logic [31:0]              cls_pressure;
    logic                     cls_snow;
    logic                     cls_sunny;
    logic                     cls_storm;
    logic                     cls_error;
    logic                     cls_done;
    logic                     busy;

    modport slave (
        input  req_valid, req_temperature, req_pressure, rsp_ready,
        input  cls_snow, cls_sunny, cls_storm, cls_error, cls_done,
        output req_ready, rsp_valid, rsp_class, rsp_timeout,
        output cls_start, cls_temperature, cls_pressure, busy
    );

    modport master (
        output req_valid, req_temperature, req_pressure, rsp_ready,
        output cls_snow, cls_sunny, cls_storm, cls_error, cls_done,
        input  req_ready, rsp_valid, rsp_class, rsp_timeout,
        input  cls_start, cls_temperature, cls_pressure, busy
    );
endinterface

// File: rtl/climate_classify_arbiter.sv
// Round-robin arbiter sharing one climate classifier among N stations.
// Define CLIMATE_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module climate_classify_arbiter #(
    parameter int unsigned N_STATIONS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    climate_classify_arbiter_if.slave     bus
);
    localparam int unsigned ID_W = (N_STATIONS > 1) ? $clog2(N_STATIONS) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [31:0]     temp_q, temp_d;
    logic [31:0]     pres_q, pres_d;
    logic [1:0]      class_q, class_d;
    logic            timeout_q, timeout_d;
    logic [ID_W-1:0] scan_idx, cand;
    logic            scan_hit;
    logic [1:0]      cls_code;

`ifdef CLIMATE_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // First requesting station at or after rr_ptr, wrapping.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int unsigned i = 0; i < N_STATIONS; i++) begin
            cand = ID_W'((32'(rr_ptr_q) + i) % N_STATIONS);
            if (!scan_hit && bus.req_valid[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    always_comb begin
        case ({bus.cls_error, bus.cls_storm, bus.cls_sunny, bus.cls_snow})
            4'b0001: cls_code = 2'd0;
            4'b0010: cls_code = 2'd1;
            4'b0100: cls_code = 2'd2;
            default: cls_code = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            temp_q    <= '0;
            pres_q    <= '0;
            class_q   <= '0;
            timeout_q <= 1'b0;
`ifdef CLIMATE_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            temp_q    <= temp_d;
            pres_q    <= pres_d;
            class_q   <= class_d;
            timeout_q <= timeout_d;
`ifdef CLIMATE_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        temp_d    = temp_q;
        pres_d    = pres_q;
        class_d   = class_q;
        timeout_d = timeout_q;
`ifdef CLIMATE_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (scan_hit) begin
                    gnt_d   = scan_idx;
                    temp_d  = bus.req_temperature[32*scan_idx +: 32];
                    pres_d  = bus.req_pressure[32*scan_idx +: 32];
                    state_d = StIssue;
                end
            end
            StIssue: begin
`ifdef CLIMATE_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (bus.cls_done) begin
                    class_d   = cls_code;
                    timeout_d = 1'b0;
                    state_d   = StRespond;
                end
`ifdef CLIMATE_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    class_d   = 2'd3;
                    timeout_d = 1'b1;
                    state_d   = StRespond;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StRespond: begin
                if (bus.rsp_ready[gnt_q]) begin
                    rr_ptr_d = (gnt_q == ID_W'(N_STATIONS - 1)) ? '0 : gnt_q + ID_W'(1);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == StIdle && scan_hit) begin
            bus.req_ready[scan_idx] = 1'b1;
        end
        bus.rsp_valid = '0;
        if (state_q == StRespond) begin
            bus.rsp_valid[gnt_q] = 1'b1;
        end
        bus.rsp_class       = class_q;
`ifdef CLIMATE_ARB_TIMEOUT_EN
        bus.rsp_timeout     = timeout_q;
`else
        bus.rsp_timeout     = 1'b0;
`endif
        bus.cls_start       = (state_q == StIssue);
        bus.cls_temperature = temp_q;
        bus.cls_pressure    = pres_q;
        bus.busy            = (state_q != StIdle);
    end
endmodule

// File: tb/tb_climate_classify_arbiter.sv
// Directed bench for climate_classify_arbiter; expected values are hand-computed.
module tb_climate_classify_arbiter;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    climate_classify_arbiter_if #(.N_STATIONS(4)) bus ();

    climate_classify_arbiter #(
        .N_STATIONS    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {bus.cls_error, bus.cls_storm, bus.cls_sunny, bus.cls_snow} = f;
    endtask

    task automatic set_lane(input int i, input logic [31:0] t, input logic [31:0] p);
        bus.req_temperature[32*i +: 32] = t;
        bus.req_pressure[32*i +: 32]    = p;
    endtask

    // Drives one transaction from IDLE with requests already presented;
    // classifier answers in the first WAIT cycle. f = {error, storm, sunny, snow}.
    task automatic do_txn(input string tag, input logic [3:0] exp_gnt, input logic [3:0] f,
                          input logic [1:0] exp_cls, input logic [31:0] exp_t,
                          input logic [31:0] exp_p);
        #1;
        check_eq({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_gnt));
        tick();
        check_eq({tag, ".cls_start"}, 64'(bus.cls_start), 64'd1);
        check_eq({tag, ".cls_temp"}, 64'(bus.cls_temperature), 64'(exp_t));
        check_eq({tag, ".cls_pres"}, 64'(bus.cls_pressure), 64'(exp_p));
        tick();
        check_eq({tag, ".start_pulse"}, 64'(bus.cls_start), 64'd0);
        set_flags(f);
        bus.cls_done = 1'b1;
        tick();
        set_flags(4'b0000);
        bus.cls_done = 1'b0;
        check_eq({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(exp_gnt));
        check_eq({tag, ".rsp_class"}, 64'(bus.rsp_class), 64'(exp_cls));
        check_eq({tag, ".rsp_timeout"}, 64'(bus.rsp_timeout), 64'd0);
        bus.rsp_ready = 4'hF;
        tick();
        bus.rsp_ready = 4'h0;
        check_eq({tag, ".idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        bus.req_valid       = '0;
        bus.req_temperature = '0;
        bus.req_pressure    = '0;
        bus.rsp_ready       = '0;
        bus.cls_done        = 1'b0;
        set_flags(4'b0000);

        // Reset state
        tick();
        tick();
        check_eq("rst.busy", 64'(bus.busy), 64'd0);
        check_eq("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst.cls_start", 64'(bus.cls_start), 64'd0);
        check_eq("rst.cls_temp", 64'(bus.cls_temperature), 64'd0);
        check_eq("rst.req_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;

        // Station 1: temp -5, pressure 1000, snow
        set_lane(1, 32'hFFFF_FFFB, 32'd1000);
        bus.req_valid = 4'b0010;
        do_txn("snow", 4'b0010, 4'b0001, 2'd0, 32'hFFFF_FFFB, 32'd1000);
        bus.req_valid = 4'b0000;

        // All stations continuously requesting, sunny: grants 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 32'(i * 7 + 3), 32'(900 + i));
        bus.req_valid = 4'hF;
        do_txn("rr0", 4'b0001, 4'b0010, 2'd1, 32'd3, 32'd900);
        do_txn("rr1", 4'b0010, 4'b0010, 2'd1, 32'd10, 32'd901);
        do_txn("rr2", 4'b0100, 4'b0010, 2'd1, 32'd17, 32'd902);
        do_txn("rr3", 4'b1000, 4'b0010, 2'd1, 32'd24, 32'd903);
        do_txn("rr4", 4'b0001, 4'b0010, 2'd1, 32'd3, 32'd900);

        // Flag encoding corner cases (pointer now 1)
        bus.req_valid = 4'b0100;
        do_txn("storm", 4'b0100, 4'b0100, 2'd2, 32'd17, 32'd902);
        bus.req_valid = 4'b0001;
        do_txn("multi", 4'b0001, 4'b0101, 2'd3, 32'd3, 32'd900);
        bus.req_valid = 4'b0010;
        do_txn("none", 4'b0010, 4'b0000, 2'd3, 32'd10, 32'd901);

        // Back-pressure: station 3 response held for 10 cycles (pointer now 2)
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        set_flags(4'b0100);
        bus.cls_done = 1'b1;
        tick();
        set_flags(4'b0000);
        bus.cls_done  = 1'b0;
        bus.req_valid = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            #1;
            check_eq("hold.rsp_valid", 64'(bus.rsp_valid), 64'b1000);
            check_eq("hold.rsp_class", 64'(bus.rsp_class), 64'd2);
            check_eq("hold.req_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 4'b1000;
        #1;
        check_eq("hs.req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.rsp_ready = 4'b0000;
        do_txn("after_hold", 4'b0001, 4'b0010, 2'd1, 32'd3, 32'd900);
        bus.req_valid = 4'b0000;

`ifdef CLIMATE_ARB_TIMEOUT_EN
        // Watchdog: station 1, classifier never answers (pointer now 1)
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        for (int k = 0; k < 15; k++) tick();
        check_eq("to.before", 64'(bus.rsp_valid), 64'd0);
        tick();
        check_eq("to.rsp_valid", 64'(bus.rsp_valid), 64'b0010);
        check_eq("to.rsp_class", 64'(bus.rsp_class), 64'd3);
        check_eq("to.rsp_timeout", 64'(bus.rsp_timeout), 64'd1);
        bus.rsp_ready = 4'hF;
        tick();
        bus.rsp_ready = 4'h0;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
`else
        // No watchdog: WAIT persists without cls_done
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        for (int k = 0; k < 20; k++) tick();
        check_eq("wait.busy", 64'(bus.busy), 64'd1);
        check_eq("wait.rsp_valid", 64'(bus.rsp_valid), 64'd0);
`endif

        // Reset while in WAIT drops the transaction
        rst_n = 1'b0;
        tick();
        check_eq("wrst.busy", 64'(bus.busy), 64'd0);
        check_eq("wrst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("wrst.cls_temp", 64'(bus.cls_temperature), 64'd0);
        check_eq("wrst.cls_pres", 64'(bus.cls_pressure), 64'd0);
        check_eq("wrst.rsp_class", 64'(bus.rsp_class), 64'd0);
        rst_n = 1'b1;
        set_flags(4'b0100);
        bus.cls_done = 1'b1;
        tick();
        set_flags(4'b0000);
        bus.cls_done = 1'b0;
        check_eq("wrst.no_rsp", 64'(bus.rsp_valid), 64'd0);
        bus.req_valid = 4'hF;
        do_txn("wrst.next", 4'b0001, 4'b1000, 2'd3, 32'd3, 32'd900);
        bus.req_valid = 4'h0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
